// File: rtl/z16_decode_stage_if.sv
// Handshake and decoded-bundle signals between fetch, the Z16 decode stage and execute.
// The slave modport is the decode stage's view; the master modport drives it.
interface z16_decode_stage_if #(
    parameter int DATA_W = 16,
    parameter int ILL_CW = 8
);
    logic              i_in_valid;
    logic              o_in_ready;
    logic [15:0]       i_instr;
    logic              o_valid;
    logic              i_out_ready;
    logic [3:0]        o_opecode;
    logic [3:0]        o_rd_addr;
    logic [3:0]        o_rs1_addr;
    logic [3:0]        o_rs2_addr;
    logic [DATA_W-1:0] o_imm;
    logic [3:0]        o_alu_ctrl;
    logic              o_rd_wen;
    logic              o_mem_ren;
    logic              o_mem_wen;
    logic              o_jump;
    logic              o_branch;
    logic              o_illegal;
    logic [ILL_CW-1:0] o_ill_count;

    modport slave (
        input  i_in_valid, i_instr, i_out_ready,
        output o_in_ready, o_valid, o_opecode, o_rd_addr, o_rs1_addr, o_rs2_addr,
               o_imm, o_alu_ctrl, o_rd_wen, o_mem_ren, o_mem_wen, o_jump, o_branch,
               o_illegal, o_ill_count
    );

    modport master (
        output i_in_valid, i_instr, i_out_ready,
        input  o_in_ready, o_valid, o_opecode, o_rd_addr, o_rs1_addr, o_rs2_addr,
               o_imm, o_alu_ctrl, o_rd_wen, o_mem_ren, o_mem_wen, o_jump, o_branch,
               o_illegal, o_ill_count
    );
endinterface

// File: rtl/z16_decode_stage.sv
// Registered Z16 decode stage: valid/ready on both sides, optional one-entry skid buffer,
// synchronous flush and a saturating count of accepted illegal opcodes.
module z16_decode_stage #(
    parameter int DATA_W  = 16,
    parameter bit SKID_EN = 1'b1,
    parameter int ILL_CW  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_flush,
    z16_decode_stage_if.slave   bus
);

    typedef struct packed {
        logic [3:0]        opcode;
        logic [3:0]        rd;
        logic [3:0]        rs1;
        logic [3:0]        rs2;
        logic [DATA_W-1:0] imm;
        logic [3:0]        alu;
        logic              rd_wen;
        logic              mem_ren;
        logic              mem_wen;
        logic              jump;
        logic              branch;
        logic              illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] sext4(input logic [3:0] f);
        return {{(DATA_W-4){f[3]}}, f};
    endfunction

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] f);
        return {{(DATA_W-8){f[7]}}, f};
    endfunction

    function automatic bundle_t decode(input logic [15:0] instr);
        bundle_t b;
        b         = {$bits(bundle_t){1'b0}};
        b.opcode  = instr[3:0];
        b.rd      = instr[7:4];
        b.rs1     = instr[11:8];
        b.rs2     = instr[15:12];
        case (instr[3:0])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                b.alu    = instr[3:0];
                b.rd_wen = 1'b1;
            end
            4'h9: begin
                b.rd_wen = 1'b1;
                b.imm    = sext8(instr[15:8]);
            end
            4'hA: begin
                b.rd_wen  = 1'b1;
                b.mem_ren = 1'b1;
                b.imm     = sext4(instr[15:12]);
            end
            4'hB: begin
                b.mem_wen = 1'b1;
                b.imm     = sext4(instr[7:4]);
            end
            4'hC: begin
                b.rd_wen = 1'b1;
                b.jump   = 1'b1;
                b.imm    = sext8(instr[15:8]);
            end
            4'hD, 4'hE: begin
                b.alu    = 4'h1;
                b.branch = 1'b1;
                b.imm    = sext4(instr[7:4]);
            end
            default: begin
                b.illegal = 1'b1;
            end
        endcase
        return b;
    endfunction

    state_t            r_state;
    logic              r_valid;
    logic              r_in_ready;
    bundle_t           r_out;
    logic [15:0]       r_skid;
    logic [ILL_CW-1:0] r_ill_cnt;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_xfer;
    logic              w_ill_inc;

    // Without the skid, r_in_ready only marks that reset has been left behind.
    assign w_in_ready = SKID_EN ? r_in_ready
                                : (r_in_ready & (bus.i_out_ready | ~r_valid));
    assign w_accept   = bus.i_in_valid & w_in_ready;
    assign w_xfer     = r_valid & bus.i_out_ready;
    assign w_ill_inc  = w_accept & (bus.i_instr[3:0] == 4'hF)
                        & (r_ill_cnt != {ILL_CW{1'b1}});

    // Pipeline register, skid buffer and handshake state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_EMPTY;
            r_valid    <= 1'b0;
            r_in_ready <= 1'b0;
            r_out      <= {$bits(bundle_t){1'b0}};
            r_skid     <= 16'h0000;
        end else if (i_flush) begin
            r_state    <= ST_EMPTY;
            r_valid    <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (SKID_EN) begin
            case (r_state)
                ST_EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_out   <= decode(bus.i_instr);
                        r_valid <= 1'b1;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_accept && !w_xfer) begin
                        r_skid     <= bus.i_instr;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_FULL;
                    end else if (w_accept) begin
                        r_out <= decode(bus.i_instr);
                    end else if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_xfer) begin
                        r_out      <= decode(r_skid);
                        r_in_ready <= 1'b1;
                        r_state    <= ST_HOLD;
                    end
                end
                default: begin
                    r_valid    <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= ST_EMPTY;
                end
            endcase
        end else begin
            r_in_ready <= 1'b1;
            if (w_accept) begin
                r_out   <= decode(bus.i_instr);
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Illegal-opcode counter; counts at accept time, so flush does not undo it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ill_cnt <= {ILL_CW{1'b0}};
        end else if (w_ill_inc) begin
            r_ill_cnt <= r_ill_cnt + {{(ILL_CW-1){1'b0}}, 1'b1};
        end
    end

    assign bus.o_in_ready  = w_in_ready;
    assign bus.o_valid     = r_valid;
    assign bus.o_opecode   = r_out.opcode;
    assign bus.o_rd_addr   = r_out.rd;
    assign bus.o_rs1_addr  = r_out.rs1;
    assign bus.o_rs2_addr  = r_out.rs2;
    assign bus.o_imm       = r_out.imm;
    assign bus.o_alu_ctrl  = r_out.alu;
    assign bus.o_rd_wen    = r_out.rd_wen;
    assign bus.o_mem_ren   = r_out.mem_ren;
    assign bus.o_mem_wen   = r_out.mem_wen;
    assign bus.o_jump      = r_out.jump;
    assign bus.o_branch    = r_out.branch;
    assign bus.o_illegal   = r_out.illegal;
    assign bus.o_ill_count = r_ill_cnt;

endmodule

// File: tb/tb_z16_decode_stage.sv
// Self-checking bench for z16_decode_stage: directed spec scenarios plus a randomized run
// checked against a depth-2 FIFO model with a table-driven decoder.
module tb_z16_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n32 = 1'b0;
    logic flush = 1'b0;
    logic flush32 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    z16_decode_stage_if #(.DATA_W(16), .ILL_CW(8)) bus ();
    z16_decode_stage_if #(.DATA_W(32), .ILL_CW(8)) bus32 ();

    z16_decode_stage #(.DATA_W(16), .SKID_EN(1'b1), .ILL_CW(8)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .bus(bus)
    );

    z16_decode_stage #(.DATA_W(32), .SKID_EN(1'b1), .ILL_CW(8)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n32), .i_flush(flush32), .bus(bus32)
    );

    always #5 clk = ~clk;

    logic [41:0] w_obs;
    logic [57:0] w_obs32;
    logic [15:0] w_word;
    assign w_obs = {bus.o_opecode, bus.o_rd_addr, bus.o_rs1_addr, bus.o_rs2_addr, bus.o_imm,
                    bus.o_alu_ctrl, bus.o_rd_wen, bus.o_mem_ren, bus.o_mem_wen, bus.o_jump,
                    bus.o_branch, bus.o_illegal};
    assign w_obs32 = {bus32.o_opecode, bus32.o_rd_addr, bus32.o_rs1_addr, bus32.o_rs2_addr,
                      bus32.o_imm, bus32.o_alu_ctrl, bus32.o_rd_wen, bus32.o_mem_ren,
                      bus32.o_mem_wen, bus32.o_jump, bus32.o_branch, bus32.o_illegal};
    assign w_word = {bus.o_rs2_addr, bus.o_rs1_addr, bus.o_rd_addr, bus.o_opecode};

    // Reference model: words accepted but not yet handed downstream, in order.
    logic [15:0] q[$];
    int  ill_exp = 0;
    bit  out_of_reset = 1'b0;

    // Expected bundle from the opcode table; enables are {rd_wen,mem_ren,mem_wen,jump,branch,illegal}.
    function automatic logic [41:0] ref_bundle(input logic [15:0] w);
        int          op;
        int          imm;
        logic [3:0]  alu;
        logic [5:0]  en;
        op  = int'(w[3:0]);
        imm = 0;
        alu = 4'h0;
        en  = 6'b000000;
        if (op <= 8) begin
            alu = w[3:0];
            en  = 6'b100000;
        end else if (op == 9) begin
            en  = 6'b100000;
            imm = int'(w[15:8]) - (w[15] ? 256 : 0);
        end else if (op == 10) begin
            en  = 6'b110000;
            imm = int'(w[15:12]) - (w[15] ? 16 : 0);
        end else if (op == 11) begin
            en  = 6'b001000;
            imm = int'(w[7:4]) - (w[7] ? 16 : 0);
        end else if (op == 12) begin
            en  = 6'b100100;
            imm = int'(w[15:8]) - (w[15] ? 256 : 0);
        end else if (op == 13 || op == 14) begin
            alu = 4'h1;
            en  = 6'b000010;
            imm = int'(w[7:4]) - (w[7] ? 16 : 0);
        end else begin
            en  = 6'b000001;
        end
        return {w[3:0], w[7:4], w[11:8], w[15:12], 16'(imm), alu, en};
    endfunction

    task automatic step(input logic v, input logic [15:0] w, input logic ordy, input logic fl);
        @(negedge clk);
        bus.i_in_valid  = v;
        bus.i_instr     = w;
        bus.i_out_ready = ordy;
        flush           = fl;
        #1;
    endtask

    // Advance the model by one clock edge using the inputs the bench is driving.
    task automatic commit();
        bit m_ready;
        bit acc;
        bit xf;
        if (!rst_n) begin
            q.delete();
            ill_exp      = 0;
            out_of_reset = 1'b0;
        end else begin
            m_ready = out_of_reset && (q.size() < 2);
            acc     = bus.i_in_valid && m_ready;
            xf      = (q.size() > 0) && bus.i_out_ready;
            if (acc && bus.i_instr[3:0] == 4'hF && ill_exp < 255) ill_exp++;
            if (flush) begin
                q.delete();
            end else begin
                if (xf) void'(q.pop_front());
                if (acc) q.push_back(bus.i_instr);
            end
            out_of_reset = 1'b1;
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
        n_checks++;
        if (bus.o_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.o_in_ready); end
        n_checks++;
        if (bus.o_ill_count !== 8'd0) begin n_fail++; $display("FAIL reset_ill_count: got %0d expected 0", bus.o_ill_count); end
        n_checks++;
        if (w_obs !== 42'd0) begin n_fail++; $display("FAIL reset_bundle: got %h expected 0", w_obs); end
        rst_n = 1'b1;
        commit();
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        n_checks++;
        if (bus.o_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.o_in_ready); end
        commit();
    endtask

    task automatic test_addi();
        step(1'b1, 16'hF239, 1'b1, 1'b0);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL addi_latency: got %b expected 0", bus.o_valid); end
        commit();
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        n_checks++;
        if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b expected 1", bus.o_valid); end
        n_checks++;
        if (bus.o_imm !== 16'hFFF2) begin n_fail++; $display("FAIL addi_imm: got %h expected fff2", bus.o_imm); end
        n_checks++;
        if ({bus.o_rd_wen, bus.o_alu_ctrl, bus.o_rd_addr, bus.o_rs1_addr} !== {1'b1, 4'h0, 4'h3, 4'h2}) begin
            n_fail++;
            $display("FAIL addi_ctrl: got wen=%b alu=%h rd=%h rs1=%h expected 1 0 3 2",
                     bus.o_rd_wen, bus.o_alu_ctrl, bus.o_rd_addr, bus.o_rs1_addr);
        end
        commit();
    endtask

    task automatic test_load_store();
        step(1'b1, 16'h721A, 1'b1, 1'b0);
        commit();
        step(1'b1, 16'h38CB, 1'b1, 1'b0);
        n_checks++;
        if (bus.o_imm !== 16'h0007) begin n_fail++; $display("FAIL load_imm: got %h expected 0007", bus.o_imm); end
        n_checks++;
        if ({bus.o_valid, bus.o_rd_wen, bus.o_mem_ren, bus.o_mem_wen} !== 4'b1110) begin
            n_fail++; $display("FAIL load_en: got %b expected 1110", {bus.o_valid, bus.o_rd_wen, bus.o_mem_ren, bus.o_mem_wen});
        end
        commit();
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        n_checks++;
        if (bus.o_imm !== 16'hFFFC) begin n_fail++; $display("FAIL store_imm: got %h expected fffc", bus.o_imm); end
        n_checks++;
        if ({bus.o_valid, bus.o_rd_wen, bus.o_mem_ren, bus.o_mem_wen} !== 4'b1001) begin
            n_fail++; $display("FAIL store_en: got %b expected 1001", {bus.o_valid, bus.o_rd_wen, bus.o_mem_ren, bus.o_mem_wen});
        end
        commit();
    endtask

    task automatic test_back_to_back();
        logic [15:0] words[3];
        words = '{16'h1230, 16'h4561, 16'h7892};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, words[i], 1'b0, 1'b0);
            n_checks++;
            if (bus.o_in_ready !== (i < 2)) begin
                n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b expected %b", i, bus.o_in_ready, (i < 2));
            end
            commit();
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0);
            n_checks++;
            if (i < 2 && (bus.o_valid !== 1'b1 || w_word !== words[i])) begin
                n_fail++; $display("FAIL b2b_order[%0d]: got v=%b %h expected v=1 %h", i, bus.o_valid, w_word, words[i]);
            end else if (i == 2 && bus.o_valid !== 1'b0) begin
                n_fail++; $display("FAIL b2b_drained: got v=%b expected 0", bus.o_valid);
            end
            commit();
        end
    endtask

    task automatic test_flush();
        step(1'b1, 16'h1113, 1'b0, 1'b0);
        commit();
        step(1'b1, 16'h2224, 1'b0, 1'b0);
        commit();
        step(1'b1, 16'h3335, 1'b0, 1'b1);
        n_checks++;
        if (bus.o_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full_ready: got %b expected 0", bus.o_in_ready); end
        commit();
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if ({bus.o_valid, bus.o_in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL flush_after: got v=%b rdy=%b expected v=0 rdy=1", bus.o_valid, bus.o_in_ready);
        end
        commit();
        step(1'b1, 16'h4446, 1'b1, 1'b0);
        commit();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0);
            n_checks++;
            if (i == 0 && (bus.o_valid !== 1'b1 || w_word !== 16'h4446)) begin
                n_fail++; $display("FAIL flush_no_stale: got v=%b %h expected v=1 4446", bus.o_valid, w_word);
            end else if (i == 1 && bus.o_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_drain: got v=%b expected 0", bus.o_valid);
            end
            commit();
        end
    endtask

    task automatic test_random();
        logic        v;
        logic        ordy;
        logic        fl;
        logic [15:0] w;
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 29) == 0);
            w    = 16'($urandom);
            if (fl && w[3:0] == 4'hF) w[3:0] = 4'h0;
            step(v, w, ordy, fl);
            n_checks++;
            if (bus.o_in_ready !== (q.size() < 2)) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, bus.o_in_ready, (q.size() < 2));
            end
            n_checks++;
            if (bus.o_valid !== (q.size() > 0)) begin
                n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, bus.o_valid, (q.size() > 0));
            end
            if (q.size() > 0) begin
                n_checks++;
                if (w_obs !== ref_bundle(q[0])) begin
                    n_fail++; $display("FAIL rnd_bundle[%0d]: got %h expected %h (word %h)", i, w_obs, ref_bundle(q[0]), q[0]);
                end
            end
            n_checks++;
            if (int'(bus.o_ill_count) != ill_exp) begin
                n_fail++; $display("FAIL rnd_ill_count[%0d]: got %0d expected %0d", i, bus.o_ill_count, ill_exp);
            end
            commit();
        end
    endtask

    task automatic test_illegal_sat();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 16'h000F, 1'b1, 1'b0);
            if (i == 5) begin
                n_checks++;
                if (w_obs !== {4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 6'b000001} || bus.o_valid !== 1'b1) begin
                    n_fail++; $display("FAIL illegal_bundle: got v=%b %h expected v=1 illegal-only", bus.o_valid, w_obs);
                end
            end
            commit();
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        n_checks++;
        if (bus.o_ill_count !== 8'd255) begin n_fail++; $display("FAIL ill_saturate: got %0d expected 255", bus.o_ill_count); end
        commit();
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        commit();
    endtask

    task automatic test_wide_and_reset();
        @(negedge clk);
        rst_n32 = 1'b1;
        bus32.i_in_valid = 1'b0;
        bus32.i_out_ready = 1'b1;
        @(negedge clk);
        bus32.i_in_valid = 1'b1;
        bus32.i_instr    = 16'h21FE;
        @(negedge clk);
        bus32.i_instr    = 16'h000F;
        #1;
        n_checks++;
        if (bus32.o_valid !== 1'b1 || bus32.o_imm !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL blt32_imm: got v=%b %h expected v=1 ffffffff", bus32.o_valid, bus32.o_imm);
        end
        n_checks++;
        if ({bus32.o_branch, bus32.o_alu_ctrl, bus32.o_rd_wen} !== {1'b1, 4'h1, 1'b0}) begin
            n_fail++; $display("FAIL blt32_ctrl: got br=%b alu=%h wen=%b expected 1 1 0",
                               bus32.o_branch, bus32.o_alu_ctrl, bus32.o_rd_wen);
        end
        @(negedge clk);
        bus32.i_instr = 16'h1230;
        #1;
        n_checks++;
        if (bus32.o_ill_count !== 8'd1 || bus32.o_illegal !== 1'b1) begin
            n_fail++; $display("FAIL wide_ill: got cnt=%0d ill=%b expected 1 1", bus32.o_ill_count, bus32.o_illegal);
        end
        #2;
        rst_n32 = 1'b0;
        #1;
        n_checks++;
        if ({bus32.o_valid, bus32.o_in_ready, bus32.o_ill_count, w_obs32} !== 68'd0) begin
            n_fail++; $display("FAIL async_reset: got v=%b rdy=%b cnt=%0d bundle=%h expected all 0",
                               bus32.o_valid, bus32.o_in_ready, bus32.o_ill_count, w_obs32);
        end
        bus32.i_in_valid = 1'b0;
    endtask

    initial begin
        bus.i_in_valid    = 1'b0;
        bus.i_instr       = 16'h0000;
        bus.i_out_ready   = 1'b0;
        bus32.i_in_valid  = 1'b0;
        bus32.i_instr     = 16'h0000;
        bus32.i_out_ready = 1'b0;
        test_reset();
        test_addi();
        test_load_store();
        test_back_to_back();
        test_flush();
        test_random();
        test_illegal_sat();
        test_wide_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
